// File: rtl/peripheral_burst_master_ahb3.sv
// Command-driven bus initiator for the ahb3-named Wishbone B3 style interface.
// Issues classic single cycles or incrementing-linear bursts of 1..16 32-bit beats.
module peripheral_burst_master_ahb3 #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          ahb3_clk_i,
  input  logic          ahb3_rst_ni,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic          cmd_we_i,
  input  logic [AW-1:0] cmd_adr_i,
  input  logic [3:0]    cmd_len_i,
  input  logic [DW-1:0] wr_dat_i,
  input  logic          wr_valid_i,
  output logic          wr_ready_o,
  output logic [DW-1:0] rd_dat_o,
  output logic          rd_valid_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic [AW-1:0] ahb3_adr_o,
  output logic [DW-1:0] ahb3_dat_o,
  output logic [3:0]    ahb3_sel_o,
  output logic          ahb3_we_o,
  output logic [2:0]    ahb3_cti_o,
  output logic [1:0]    ahb3_bte_o,
  output logic          ahb3_cyc_o,
  output logic          ahb3_stb_o,
  input  logic          ahb3_ack_i,
  input  logic          ahb3_err_i,
  input  logic [DW-1:0] ahb3_dat_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] adr_reg;
  logic          we_reg;
  logic [3:0]    len_reg;
  logic [3:0]    cnt_reg;
  logic [DW-1:0] rd_dat_reg;
  logic          rd_valid_reg;
  logic          err_reg;

  logic          xfer;
  logic          accept;
  logic          beat_ok;
  logic          beat_err;
  logic          last_beat;

  assign xfer      = (state_reg == XFER);
  assign accept    = (state_reg == IDLE) && cmd_valid_i;
  assign last_beat = (cnt_reg == len_reg);

  // Writes only strobe when a data word is actually available.
  assign ahb3_stb_o = xfer && (we_reg ? wr_valid_i : 1'b1);
  assign ahb3_cyc_o = xfer;
  assign beat_err   = ahb3_stb_o && ahb3_err_i;
  assign beat_ok    = ahb3_stb_o && ahb3_ack_i && !ahb3_err_i;

  assign ahb3_adr_o = adr_reg;
  assign ahb3_dat_o = wr_dat_i;
  assign ahb3_sel_o = {4{xfer}};
  assign ahb3_we_o  = we_reg;
  assign ahb3_bte_o = 2'b00;
  assign ahb3_cti_o = (!xfer || len_reg == 4'd0) ? 3'b000 :
                      (last_beat ? 3'b111 : 3'b010);

  assign wr_ready_o = beat_ok && we_reg;
  assign rd_dat_o   = rd_dat_reg;
  assign rd_valid_o = rd_valid_reg;
  assign err_o      = err_reg;

  always_ff @(posedge ahb3_clk_i or negedge ahb3_rst_ni) begin
    if (!ahb3_rst_ni) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cmd_ready_o = 1'b0;
    busy_o      = 1'b1;
    done_o      = 1'b0;
    case (state_reg)
      IDLE: begin
        cmd_ready_o = 1'b1;
        busy_o      = 1'b0;
        if (cmd_valid_i) state_next = XFER;
      end
      XFER: begin
        // An error ends the transfer at once; a normal end needs the final ack.
        if (beat_err || (beat_ok && last_beat)) state_next = DONE;
      end
      DONE: begin
        done_o     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ahb3_clk_i or negedge ahb3_rst_ni) begin
    if (!ahb3_rst_ni) begin
      adr_reg      <= '0;
      we_reg       <= 1'b0;
      len_reg      <= 4'd0;
      cnt_reg      <= 4'd0;
      rd_dat_reg   <= '0;
      rd_valid_reg <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      rd_valid_reg <= beat_ok && !we_reg;
      if (beat_ok && !we_reg) rd_dat_reg <= ahb3_dat_i;
      if (accept) begin
        adr_reg <= cmd_adr_i & ~AW'(3);
        we_reg  <= cmd_we_i;
        len_reg <= cmd_len_i;
        cnt_reg <= 4'd0;
        err_reg <= 1'b0;
      end else begin
        if (beat_ok) begin
          adr_reg <= adr_reg + AW'(4);
          cnt_reg <= cnt_reg + 4'd1;
        end
        if (beat_err) err_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_peripheral_burst_master_ahb3.sv
// Table-driven bench for peripheral_burst_master_ahb3 against a registered-ack
// SPRAM-style responder, with a read-data scoreboard queue.
module tb_peripheral_burst_master_ahb3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr;
  logic [3:0]  cmd_len;
  logic [31:0] wr_dat;
  logic        wr_valid, wr_ready;
  logic [31:0] rd_dat;
  logic        rd_valid, busy, done, err;
  logic [31:0] adr_o, dat_o, dat_i;
  logic [3:0]  sel_o;
  logic        we_o, cyc_o, stb_o, ack_i, err_i;
  logic [2:0]  cti_o;
  logic [1:0]  bte_o;

  always #5 clk = ~clk;

  peripheral_burst_master_ahb3 #(.AW(32), .DW(32)) dut (
    .ahb3_clk_i(clk), .ahb3_rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_len_i(cmd_len),
    .wr_dat_i(wr_dat), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
    .rd_dat_o(rd_dat), .rd_valid_o(rd_valid),
    .busy_o(busy), .done_o(done), .err_o(err),
    .ahb3_adr_o(adr_o), .ahb3_dat_o(dat_o), .ahb3_sel_o(sel_o), .ahb3_we_o(we_o),
    .ahb3_cti_o(cti_o), .ahb3_bte_o(bte_o), .ahb3_cyc_o(cyc_o), .ahb3_stb_o(stb_o),
    .ahb3_ack_i(ack_i), .ahb3_err_i(err_i), .ahb3_dat_i(dat_i)
  );

  // Responder: registered ack, keeps acking while an incrementing burst continues.
  logic [31:0] mem    [0:1023];
  logic [31:0] shadow [0:1023];
  logic        ack_q;
  logic        err_arm = 1'b0;
  logic [31:0] err_adr = '0;

  assign ack_i = ack_q;
  assign err_i = ack_q && err_arm && (adr_o == err_adr);
  assign dat_i = mem[adr_o[11:2]];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ack_q <= 1'b0;
    else ack_q <= cyc_o && stb_o && !(ack_q && (cti_o != 3'b010));
  end

  always @(posedge clk) begin
    if (cyc_o && stb_o && ack_q && !err_i && we_o) mem[adr_o[11:2]] <= dat_o;
  end

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  len;
    int          stall_at;
    int          stall_len;
    int          err_beat;
    int          rst_beat;
    logic        hold;
    int          exp_beats;
    logic        exp_err;
    int          exp_done;
    logic [31:0] exp_last_adr;
    logic [2:0]  exp_last_cti;
  } vec_t;

  vec_t        vecs [12];
  logic [31:0] rd_q [$];
  int          checks = 0;
  int          errors = 0;
  int          cur_row = -1;
  logic        err_prev = 1'b0;

  logic        cur_we;
  int          cur_len, wr_idx, stall_at, stall_left;
  logic [31:0] wdata_m [16];

  function automatic vec_t mk(input logic we, input logic [31:0] adr, input int len,
                              input int s_at, input int s_len, input int e_beat,
                              input int r_beat, input logic hold, input int beats,
                              input logic e_err, input int dn, input logic [31:0] l_adr,
                              input logic [2:0] l_cti);
    vec_t v;
    v.we = we; v.adr = adr; v.len = 4'(len); v.stall_at = s_at; v.stall_len = s_len;
    v.err_beat = e_beat; v.rst_beat = r_beat; v.hold = hold; v.exp_beats = beats;
    v.exp_err = e_err; v.exp_done = dn; v.exp_last_adr = l_adr; v.exp_last_cti = l_cti;
    return v;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(a[11:2]);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL row%0d %s: got 0x%0h, expected 0x%0h", cur_row, name, act, exp);
    end
  endtask

  task automatic drive_wr();
    wr_dat = (wr_idx < 16) ? wdata_m[wr_idx] : 32'h0;
    if (cur_we && wr_idx <= cur_len) begin
      if (wr_idx == stall_at && stall_left > 0) begin
        wr_valid = 1'b0;
        stall_left--;
      end else begin
        wr_valid = 1'b1;
      end
    end else begin
      wr_valid = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ctl"}, {cyc_o, stb_o, sel_o, we_o, cti_o, bte_o, rd_valid, done, err, busy, wr_ready}, 64'h0);
    chk({tag, "_adr"}, adr_o, 64'h0);
    chk({tag, "_rd_dat"}, rd_dat, 64'h0);
  endtask

  task automatic run_vec(input int i);
    vec_t        v;
    logic [31:0] start, eadr;
    logic [2:0]  ecti, last_cti;
    logic [31:0] last_adr;
    int          n_rd, bidx, wr_cnt, rd_cnt, done_cnt, stall_seen, cycles;
    logic        done_seen, rst_done, fin_prev, fin_now, exp_wr_ready;
    v = vecs[i];
    cur_row = i;
    start = v.adr & 32'hFFFF_FFFC;
    bidx = 0; wr_cnt = 0; rd_cnt = 0; done_cnt = 0; stall_seen = 0; cycles = 0;
    done_seen = 1'b0; rst_done = 1'b0; fin_prev = 1'b0;
    last_adr = 32'hFFFF_FFFF; last_cti = 3'b101;
    for (int b = 0; b < 16; b++) wdata_m[b] = (i == 0) ? 32'hDEADBEEF : $urandom;
    if (v.we && v.rst_beat < 0)
      for (int b = 0; b <= int'(v.len); b++) shadow[widx(start + 32'(4 * b))] = wdata_m[b];
    if (!v.we) begin
      n_rd = (v.err_beat >= 0) ? v.err_beat : int'(v.len) + 1;
      for (int b = 0; b < n_rd; b++) rd_q.push_back(shadow[widx(start + 32'(4 * b))]);
    end
    err_arm = (v.err_beat >= 0);
    err_adr = start + 32'(4 * v.err_beat);
    cur_we = v.we; cur_len = int'(v.len); wr_idx = 0;
    stall_at = v.stall_at; stall_left = v.stall_len;
    cmd_we = v.we; cmd_adr = v.adr; cmd_len = v.len; cmd_valid = 1'b1;
    drive_wr();

    @(negedge clk);
    chk("ready_idle", cmd_ready, 1);
    chk("busy_idle", busy, 0);
    chk("err_sticky_before_accept", err, err_prev);
    @(posedge clk); #1;
    if (v.hold) begin
      cmd_we = vecs[i+1].we; cmd_adr = vecs[i+1].adr; cmd_len = vecs[i+1].len;
    end else begin
      cmd_valid = 1'b0;
    end
    drive_wr();

    while (!done_seen && !rst_done && cycles < 100) begin
      cycles++;
      @(negedge clk);
      if (v.rst_beat >= 0 && bidx == v.rst_beat) begin
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        wr_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("no_done_in_reset", done, 0);
        rst_n = 1'b1;
        rst_done = 1'b1;
      end else begin
        chk("ready_vs_busy", cmd_ready, !busy);
        fin_now = 1'b0;
        if (cyc_o) begin
          eadr = start + 32'(4 * bidx);
          ecti = (v.len == 4'd0) ? 3'b000 : ((bidx == int'(v.len)) ? 3'b111 : 3'b010);
          chk("adr", adr_o, eadr);
          chk("cti", cti_o, ecti);
          chk("sel_cyc", sel_o, 4'hF);
          chk("bte", bte_o, 2'b00);
          chk("we", we_o, v.we);
          if (!stb_o) stall_seen++;
        end else begin
          chk("sel_idle", sel_o, 4'h0);
        end
        exp_wr_ready = cyc_o && stb_o && ack_i && !err_i && v.we;
        chk("wr_ready", wr_ready, exp_wr_ready);
        if (cyc_o && stb_o) begin
          last_adr = adr_o;
          last_cti = cti_o;
          if (err_i) fin_now = 1'b1;
          else if (ack_i) begin
            if (bidx == int'(v.len)) fin_now = 1'b1;
            bidx++;
          end
        end
        if (wr_ready) begin
          chk("wr_dat", dat_o, (wr_idx < 16) ? wdata_m[wr_idx] : 32'h0);
          wr_idx++;
          wr_cnt++;
        end
        if (rd_valid) begin
          rd_cnt++;
          checks++;
          if (rd_q.size() == 0) begin
            errors++;
            $display("FAIL row%0d rd_unexpected: got 0x%0h, expected no read beat", cur_row, rd_dat);
          end else begin
            eadr = rd_q.pop_front();
            if (rd_dat !== eadr) begin
              errors++;
              $display("FAIL row%0d rd_dat: got 0x%0h, expected 0x%0h", cur_row, rd_dat, eadr);
            end
          end
        end
        if (done) begin
          done_cnt++;
          done_seen = 1'b1;
          chk("done_after_last_beat", fin_prev, 1);
          chk("cyc_low_in_done", cyc_o, 0);
        end
        fin_prev = fin_now;
        @(posedge clk); #1;
        drive_wr();
      end
    end
    if (!done_seen && !rst_done) begin
      checks++;
      errors++;
      $display("FAIL row%0d timeout: got no done_o, expected one within 100 cycles", cur_row);
    end
    if (rst_done) begin
      @(posedge clk); #1;
    end

    chk("end_busy", busy, 0);
    chk("end_ready", cmd_ready, 1);
    chk("end_err", err, v.exp_err);
    chk("beats", v.we ? wr_cnt : rd_cnt, v.exp_beats);
    chk("done_pulses", done_cnt, v.exp_done);
    chk("rd_left", rd_q.size(), 0);
    chk("stall_cycles", stall_seen, v.stall_len);
    chk("last_adr", last_adr, v.exp_last_adr);
    chk("last_cti", last_cti, v.exp_last_cti);
    $display("row%0d we=%0d adr=0x%08h len=%0d beats=%0d err=%0d done=%0d", i, v.we, v.adr,
             v.len, v.we ? wr_cnt : rd_cnt, err, done_cnt);
    err_prev = v.exp_err;
    err_arm = 1'b0;
    rd_q.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_len = '0;
    wr_dat = '0; wr_valid = 1'b0;
    for (int k = 0; k < 1024; k++) begin
      mem[k]    = 32'hC0DE_0000 | 32'(k);
      shadow[k] = 32'hC0DE_0000 | 32'(k);
    end
    for (int k = 0; k < 4; k++) begin
      mem[8 + k]    = 32'(k + 1);
      shadow[8 + k] = 32'(k + 1);
    end
    //          we  adr            len s_at s_len err rst hold beats err done last_adr      cti
    vecs[0]  = mk(1, 32'h10,        0, -1, 0, -1, -1, 0,  1, 0, 1, 32'h10,       3'b000);
    vecs[1]  = mk(0, 32'h10,        0, -1, 0, -1, -1, 0,  1, 0, 1, 32'h10,       3'b000);
    vecs[2]  = mk(0, 32'h20,        3, -1, 0, -1, -1, 0,  4, 0, 1, 32'h2C,       3'b111);
    vecs[3]  = mk(1, 32'h3F0,      15,  5, 3, -1, -1, 0, 16, 0, 1, 32'h42C,      3'b111);
    vecs[4]  = mk(0, 32'h3F0,      15, -1, 0, -1, -1, 0, 16, 0, 1, 32'h42C,      3'b111);
    vecs[5]  = mk(0, 32'h100,       7, -1, 0,  2, -1, 0,  2, 1, 1, 32'h108,      3'b010);
    vecs[6]  = mk(0, 32'h20,        1, -1, 0, -1, -1, 1,  2, 0, 1, 32'h24,       3'b111);
    vecs[7]  = mk(0, 32'h3F4,       0, -1, 0, -1, -1, 0,  1, 0, 1, 32'h3F4,      3'b000);
    vecs[8]  = mk(1, 32'hFFFFFFFB,  3, -1, 0, -1, -1, 0,  4, 0, 1, 32'h4,        3'b111);
    vecs[9]  = mk(0, 32'hFFFFFFF9,  3, -1, 0, -1, -1, 0,  4, 0, 1, 32'h4,        3'b111);
    vecs[10] = mk(1, 32'h200,      15, -1, 0, -1,  7, 0,  7, 0, 0, 32'h218,      3'b010);
    vecs[11] = mk(0, 32'h10,        0, -1, 0, -1, -1, 0,  1, 0, 1, 32'h10,       3'b000);

    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    chk("por_ready", cmd_ready, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) run_vec(i);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
